// File: rtl/btn_press_classifier_pkg.sv
// Shared types and default timing for the button press classifier.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  localparam int PRESS_CNT_W       = 8;
  localparam int DEF_LONG_CYCLES   = 25_000_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

endpackage

// File: rtl/btn_press_classifier_if.sv
// Button classifier bus: enable and level in, event pulses and status out.
interface btn_press_classifier_if;
  import btn_pkg::*;

  logic                   en;
  logic                   debounced;
  logic                   press_pulse;
  logic                   release_pulse;
  logic                   short_press;
  logic                   long_press;
  logic                   repeat_pulse;
  logic                   held;
  logic [PRESS_CNT_W-1:0] press_count;

  modport master (
    output en, debounced,
    input  press_pulse, release_pulse, short_press, long_press,
    input  repeat_pulse, held, press_count
  );

  modport slave (
    input  en, debounced,
    output press_pulse, release_pulse, short_press, long_press,
    output repeat_pulse, held, press_count
  );

endinterface

// File: rtl/btn_press_classifier_edge_det.sv
// Rise/fall detector on the debounced level; prev resets high so a button
// held through reset is not mistaken for a fresh press.
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise,
  output logic fall
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= in;
    end
  end

  assign rise = in & ~r_prev;
  assign fall = ~in & r_prev;

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button level into press/release/short/long/repeat
// pulses plus a held level and a wrapping press counter; all outputs registered.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = $clog2(LONG_CYCLES + 1)
) (
  input logic                   clk,
  input logic                   rst_n,
  btn_press_classifier_if.slave bus
);

  localparam int REP_NEED = $clog2(REPEAT_CYCLES + 1);
  localparam int REP_W    = (CNT_W > REP_NEED) ? CNT_W : REP_NEED;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic w_rise;
  logic w_fall;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic [REP_W-1:0]       r_rep_cnt;
  logic                   r_press_pulse;
  logic                   r_release_pulse;
  logic                   r_short_press;
  logic                   r_long_press;
  logic                   r_repeat_pulse;
  logic                   r_held;
  logic [PRESS_CNT_W-1:0] r_press_count;

  btn_edge_det u_edge_det (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (bus.debounced),
    .rise  (w_rise),
    .fall  (w_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_hold_cnt      <= '0;
      r_rep_cnt       <= '0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_press   <= 1'b0;
      r_long_press    <= 1'b0;
      r_repeat_pulse  <= 1'b0;
      r_held          <= 1'b0;
      r_press_count   <= '0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_press   <= 1'b0;
      r_long_press    <= 1'b0;
      r_repeat_pulse  <= 1'b0;

      // Disable aborts silently: no release for the press in flight.
      if (!bus.en) begin
        r_state    <= IDLE;
        r_held     <= 1'b0;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              r_state       <= PRESSED;
              r_hold_cnt    <= CNT_W'(1);
              r_press_pulse <= 1'b1;
              r_press_count <= r_press_count + 1'b1;
              r_held        <= 1'b1;
            end
          end

          PRESSED: begin
            if (w_fall) begin
              r_state         <= IDLE;
              r_short_press   <= 1'b1;
              r_release_pulse <= 1'b1;
              r_held          <= 1'b0;
              r_hold_cnt      <= '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
              r_state      <= LONG_HELD;
              r_long_press <= 1'b1;
              r_hold_cnt   <= r_hold_cnt + 1'b1;
              r_rep_cnt    <= '0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end

          LONG_HELD: begin
            // Fall takes priority over a repeat due on the same edge.
            if (w_fall) begin
              r_state         <= IDLE;
              r_release_pulse <= 1'b1;
              r_held          <= 1'b0;
              r_hold_cnt      <= '0;
              r_rep_cnt       <= '0;
            end else if (r_rep_cnt == REP_LAST) begin
              r_repeat_pulse <= 1'b1;
              r_rep_cnt      <= '0;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end

          default: begin
            r_state <= IDLE;
            r_held  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign bus.short_press   = r_short_press;
  assign bus.long_press    = r_long_press;
  assign bus.repeat_pulse  = r_repeat_pulse;
  assign bus.held          = r_held;
  assign bus.press_count   = r_press_count;

endmodule
